// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode initialization sequencer.
package sd_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PWRUP     = 4'd1,
    ST_GAP       = 4'd2,
    ST_SEND_CMD  = 4'd3,
    ST_POLL_R1   = 4'd4,
    ST_READ_TAIL = 4'd5,
    ST_EVAL      = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CMD_SEL_0  = 3'd0,
    CMD_SEL_8  = 3'd1,
    CMD_SEL_55 = 3'd2,
    CMD_SEL_41 = 3'd3,
    CMD_SEL_58 = 3'd4
  } cmd_e;

  localparam logic [5:0]  CMD0_IDX   = 6'd0;
  localparam logic [5:0]  CMD8_IDX   = 6'd8;
  localparam logic [5:0]  CMD55_IDX  = 6'd55;
  localparam logic [5:0]  ACMD41_IDX = 6'd41;
  localparam logic [5:0]  CMD58_IDX  = 6'd58;

  localparam logic [7:0]  CRC_CMD0   = 8'h95;
  localparam logic [7:0]  CRC_CMD8   = 8'h87;
  localparam logic [7:0]  CRC_DUMMY  = 8'h01;

  localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
  localparam logic [11:0] CMD8_CHECK     = 12'h1AA;
  localparam logic [31:0] ACMD41_HCS_ARG = 32'h4000_0000;

  localparam logic [7:0]  R1_READY = 8'h00;
  localparam logic [7:0]  R1_IDLE  = 8'h01;
  localparam logic [7:0]  IDLE_BYTE = 8'hFF;

  localparam logic [2:0]  ERR_NONE   = 3'd0;
  localparam logic [2:0]  ERR_NCR    = 3'd1;
  localparam logic [2:0]  ERR_CMD0   = 3'd2;
  localparam logic [2:0]  ERR_CMD8   = 3'd3;
  localparam logic [2:0]  ERR_CMD55  = 3'd4;
  localparam logic [2:0]  ERR_ACMD41 = 3'd5;
  localparam logic [2:0]  ERR_CMD58  = 3'd6;

  // R7 (CMD8) and OCR (CMD58) responses carry four bytes after R1.
  function automatic logic cmd_has_tail(input cmd_e cmd);
    case (cmd)
      CMD_SEL_8, CMD_SEL_58: cmd_has_tail = 1'b1;
      default:               cmd_has_tail = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sd_spi_cmd_frame.sv
// Combinational selector for the six bytes of a fixed SD command frame.
module sd_spi_cmd_frame
  import sd_spi_pkg::*;
(
  input  cmd_e       cmd_sel_i,
  input  logic [2:0] byte_idx_i,
  output logic [7:0] tx_byte_o
);

  logic [5:0]  idx_s;
  logic [31:0] arg_s;
  logic [7:0]  crc_s;

  always_comb begin
    idx_s = CMD0_IDX;
    arg_s = 32'h0000_0000;
    crc_s = CRC_DUMMY;
    case (cmd_sel_i)
      CMD_SEL_0:  begin idx_s = CMD0_IDX;   crc_s = CRC_CMD0; end
      CMD_SEL_8:  begin idx_s = CMD8_IDX;   arg_s = CMD8_ARG; crc_s = CRC_CMD8; end
      CMD_SEL_55: begin idx_s = CMD55_IDX;  end
      CMD_SEL_41: begin idx_s = ACMD41_IDX; arg_s = ACMD41_HCS_ARG; end
      CMD_SEL_58: begin idx_s = CMD58_IDX;  end
      default:    begin idx_s = CMD0_IDX;   crc_s = CRC_CMD0; end
    endcase
  end

  always_comb begin
    case (byte_idx_i)
      3'd0:    tx_byte_o = {2'b01, idx_s};
      3'd1:    tx_byte_o = arg_s[31:24];
      3'd2:    tx_byte_o = arg_s[23:16];
      3'd3:    tx_byte_o = arg_s[15:8];
      3'd4:    tx_byte_o = arg_s[7:0];
      3'd5:    tx_byte_o = crc_s;
      default: tx_byte_o = IDLE_BYTE;
    endcase
  end

endmodule

// File: rtl/sd_card_spi_init_seq.sv
// SD-card SPI-mode power-up/initialization sequencer driving a shared byte engine.
// Optional CMD58 (OCR / high-capacity) step is enabled by defining SD_INIT_CMD58_EN.
module sd_card_spi_init_seq
  import sd_spi_pkg::*;
#(
  parameter int PWRUP_BYTES      = 10,
  parameter int NCR_MAX          = 8,
  parameter int ACMD41_RETRY_MAX = 1000
) (
  input  logic       clk210_p,
  input  logic       reset_p,
  input  logic       init_start_p,
  input  logic       xfer_done_p,
  input  logic [7:0] xfer_rx_byte_p,
  output logic       xfer_req_p,
  output logic [7:0] xfer_tx_byte_p,
  output logic       sd_spi_cs_n_p,
  output logic       sd_spi_use_normal_baud_p,
  output logic       init_busy_p,
  output logic       init_done_p,
  output logic       init_err_p,
  output logic [2:0] err_code_p,
  output logic       sd_hc_p
);

`ifdef SD_INIT_CMD58_EN
  localparam int TAIL_W = 32;
`else
  localparam int TAIL_W = 12;
`endif

  localparam logic [7:0]  PWRUP_LAST = 8'(PWRUP_BYTES - 1);
  localparam logic [7:0]  NCR_LAST   = 8'(NCR_MAX - 1);
  localparam logic [15:0] RETRY_MAX  = 16'(ACMD41_RETRY_MAX);

  state_e              state_q, state_d, gap_next_q, gap_next_d;
  cmd_e                cmd_q, cmd_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [15:0]         retry_q, retry_d, retry_inc_s;
  logic [TAIL_W-1:0]   tail_q, tail_d;
  logic [7:0]          r1_q, r1_d;
  logic [2:0]          pend_code_q, pend_code_d;
  logic                req_q, req_d;
  logic [7:0]          tx_q, tx_d;
  logic                cs_n_q, cs_n_d;
  logic                baud_q, baud_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, hc_q, hc_d;
  logic [2:0]          code_q, code_d;
  logic [7:0]          frame_byte_s;

  sd_spi_cmd_frame u_frame (
    .cmd_sel_i  (cmd_q),
    .byte_idx_i (cnt_q[2:0]),
    .tx_byte_o  (frame_byte_s)
  );

  assign retry_inc_s = retry_q + 16'd1;

  // Next-state and next-output logic; a request is raised only from a cycle with req low.
  always_comb begin
    state_d = state_q; gap_next_d = gap_next_q; cmd_d = cmd_q; cnt_d = cnt_q;
    retry_d = retry_q; tail_d = tail_q; r1_d = r1_q; pend_code_d = pend_code_q;
    req_d = req_q; tx_d = tx_q; cs_n_d = cs_n_q; baud_d = baud_q;
    busy_d = busy_q; done_d = done_q; err_d = err_q; code_d = code_q; hc_d = hc_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (init_start_p) begin
          state_d = ST_PWRUP; cnt_d = 8'd0; retry_d = 16'd0; cs_n_d = 1'b1;
          baud_d = 1'b0; busy_d = 1'b1; done_d = 1'b0; err_d = 1'b0;
          code_d = ERR_NONE; hc_d = 1'b0; pend_code_d = ERR_NONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_PWRUP: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = IDLE_BYTE;
        end else if (xfer_done_p) begin
          req_d = 1'b0;
          if (cnt_q == PWRUP_LAST) begin
            cnt_d = 8'd0; cmd_d = CMD_SEL_0; cs_n_d = 1'b0; state_d = ST_SEND_CMD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_SEND_CMD: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = frame_byte_s;
        end else if (xfer_done_p) begin
          req_d = 1'b0;
          if (cnt_q == 8'd5) begin
            cnt_d = 8'd0; state_d = ST_POLL_R1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_POLL_R1: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = IDLE_BYTE;
        end else if (xfer_done_p) begin
          req_d = 1'b0; cnt_d = 8'd0;
          if (!xfer_rx_byte_p[7]) begin
            r1_d = xfer_rx_byte_p;
            state_d = cmd_has_tail(cmd_q) ? ST_READ_TAIL : ST_EVAL;
          end else if (cnt_q == NCR_LAST) begin
            pend_code_d = ERR_NCR; gap_next_d = ST_ERROR; cs_n_d = 1'b1; state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_READ_TAIL: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = IDLE_BYTE;
        end else if (xfer_done_p) begin
          req_d = 1'b0;
          tail_d = {tail_q[TAIL_W-9:0], xfer_rx_byte_p};
          if (cnt_q == 8'd3) begin
            cnt_d = 8'd0; state_d = ST_EVAL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_EVAL: begin
        // Every outcome passes through one CS-high GAP byte.
        state_d = ST_GAP; cs_n_d = 1'b1; gap_next_d = ST_SEND_CMD;
        case (cmd_q)
          CMD_SEL_0: begin
            if (r1_q == R1_IDLE) begin
              cmd_d = CMD_SEL_8;
            end else begin
              gap_next_d = ST_ERROR; pend_code_d = ERR_CMD0;
            end
          end
          CMD_SEL_8: begin
            if (r1_q == R1_IDLE && tail_q[11:0] == CMD8_CHECK) begin
              cmd_d = CMD_SEL_55;
            end else begin
              gap_next_d = ST_ERROR; pend_code_d = ERR_CMD8;
            end
          end
          CMD_SEL_55: begin
            if (r1_q == R1_READY || r1_q == R1_IDLE) begin
              cmd_d = CMD_SEL_41;
            end else begin
              gap_next_d = ST_ERROR; pend_code_d = ERR_CMD55;
            end
          end
          CMD_SEL_41: begin
            if (r1_q == R1_READY) begin
`ifdef SD_INIT_CMD58_EN
              cmd_d = CMD_SEL_58;
`else
              gap_next_d = ST_DONE;
`endif
            end else if (r1_q == R1_IDLE) begin
              retry_d = retry_inc_s;
              if (retry_inc_s == RETRY_MAX) begin
                gap_next_d = ST_ERROR; pend_code_d = ERR_ACMD41;
              end else begin
                cmd_d = CMD_SEL_55;
              end
            end else begin
              gap_next_d = ST_ERROR; pend_code_d = ERR_CMD55;
            end
          end
`ifdef SD_INIT_CMD58_EN
          CMD_SEL_58: begin
            if (r1_q == R1_READY) begin
              hc_d = tail_q[30]; gap_next_d = ST_DONE;
            end else begin
              gap_next_d = ST_ERROR; pend_code_d = ERR_CMD58;
            end
          end
`endif
          default: begin
            gap_next_d = ST_ERROR; pend_code_d = ERR_CMD0;
          end
        endcase
      end
      ST_GAP: begin
        if (!req_q) begin
          req_d = 1'b1; tx_d = IDLE_BYTE;
        end else if (xfer_done_p) begin
          req_d = 1'b0; cnt_d = 8'd0;
          if (gap_next_q == ST_SEND_CMD) begin
            cs_n_d = 1'b0; state_d = ST_SEND_CMD;
          end else if (gap_next_q == ST_DONE) begin
            baud_d = 1'b1; done_d = 1'b1; busy_d = 1'b0; state_d = ST_DONE;
          end else begin
            err_d = 1'b1; code_d = pend_code_q; busy_d = 1'b0; state_d = ST_ERROR;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE; gap_next_q <= ST_SEND_CMD; cmd_q <= CMD_SEL_0;
      cnt_q <= 8'd0; retry_q <= 16'd0; tail_q <= '0; r1_q <= 8'hFF;
      pend_code_q <= ERR_NONE; req_q <= 1'b0; tx_q <= IDLE_BYTE; cs_n_q <= 1'b1;
      baud_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      code_q <= ERR_NONE; hc_q <= 1'b0;
    end else begin
      state_q <= state_d; gap_next_q <= gap_next_d; cmd_q <= cmd_d;
      cnt_q <= cnt_d; retry_q <= retry_d; tail_q <= tail_d; r1_q <= r1_d;
      pend_code_q <= pend_code_d; req_q <= req_d; tx_q <= tx_d; cs_n_q <= cs_n_d;
      baud_q <= baud_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      code_q <= code_d; hc_q <= hc_d;
    end
  end

  assign xfer_req_p               = req_q;
  assign xfer_tx_byte_p           = tx_q;
  assign sd_spi_cs_n_p            = cs_n_q;
  assign sd_spi_use_normal_baud_p = baud_q;
  assign init_busy_p              = busy_q;
  assign init_done_p              = done_q;
  assign init_err_p               = err_q;
  assign err_code_p               = code_q;
  assign sd_hc_p                  = hc_q;

endmodule

// File: tb/tb_sd_card_spi_init_seq.sv
// Directed bench: byte-engine + SD card model, handshake monitor, linear scenario list.
module tb_sd_card_spi_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, xfer_done;
  logic [7:0] xfer_rx;
  logic       req, cs_n, baud, busy, done, err, hc;
  logic [7:0] tx;
  logic [2:0] code;

  sd_card_spi_init_seq #(.PWRUP_BYTES(10), .NCR_MAX(8), .ACMD41_RETRY_MAX(3)) dut (
    .clk210_p(clk), .reset_p(reset), .init_start_p(start),
    .xfer_done_p(xfer_done), .xfer_rx_byte_p(xfer_rx),
    .xfer_req_p(req), .xfer_tx_byte_p(tx), .sd_spi_cs_n_p(cs_n),
    .sd_spi_use_normal_baud_p(baud), .init_busy_p(busy), .init_done_p(done),
    .init_err_p(err), .err_code_p(code), .sd_hc_p(hc)
  );

`ifdef SD_INIT_CMD58_EN
  localparam int EXP_HC = 1, EXP_CMD58 = 1, EXP_GAPS = 9;
`else
  localparam int EXP_HC = 0, EXP_CMD58 = 0, EXP_GAPS = 8;
`endif
  localparam int M_NOMINAL = 0, M_NOCARD = 1, M_ECHO = 2, M_TIMEOUT = 3;

  int n_cmp = 0, n_bad = 0;
  int mode = M_NOMINAL, dly_min = 1, dly_max = 3;
  logic model_clr = 1'b0, clr_seen = 1'b0;

  int pwrup_cnt, gap_cnt, byte_cnt, cnt0, cnt8, cnt55, cnt41, cnt58, bad_frame, frame_cnt;
  bit seen_cmd;
  logic [7:0] frame [6];
  logic [7:0] rq [$];
  int viol_tx = 0, viol_hs = 0, viol_cs = 0, viol_baud = 0;

  function automatic logic [7:0] exp_frame_byte(input logic [5:0] idx, input int k);
    logic [31:0] arg; logic [7:0] crc;
    arg = 32'h0; crc = 8'h01;
    if (idx == 6'd0) crc = 8'h95;
    if (idx == 6'd8) begin arg = 32'h0000_01AA; crc = 8'h87; end
    if (idx == 6'd41) arg = 32'h4000_0000;
    case (k)
      0: return {2'b01, idx};
      1: return arg[31:24];
      2: return arg[23:16];
      3: return arg[15:8];
      4: return arg[7:0];
      default: return crc;
    endcase
  endfunction

  task automatic clear_model();
    pwrup_cnt = 0; gap_cnt = 0; byte_cnt = 0; cnt0 = 0; cnt8 = 0; cnt55 = 0;
    cnt41 = 0; cnt58 = 0; bad_frame = 0; frame_cnt = 0; seen_cmd = 0; rq.delete();
  endtask

  task automatic respond(input logic [7:0] b0);
    if (mode != M_NOCARD) begin rq.push_back(8'hFF); rq.push_back(b0); end
  endtask

  task automatic decode();
    logic [5:0] idx;
    idx = frame[0][5:0];
    for (int k = 0; k < 6; k++) if (frame[k] !== exp_frame_byte(idx, k)) bad_frame++;
    case (idx)
      6'd0:  begin cnt0++; respond(8'h01); end
      6'd8:  begin
        cnt8++; respond(8'h01);
        if (mode != M_NOCARD) begin
          rq.push_back(8'h00); rq.push_back(8'h00); rq.push_back(8'h01);
          rq.push_back(mode == M_ECHO ? 8'hAB : 8'hAA);
        end
      end
      6'd55: begin cnt55++; respond(8'h01); end
      6'd41: begin cnt41++; respond((mode == M_TIMEOUT || cnt41 < 3) ? 8'h01 : 8'h00); end
      6'd58: begin
        cnt58++; respond(8'h00);
        if (mode != M_NOCARD) begin
          rq.push_back(8'hC0); rq.push_back(8'hFF); rq.push_back(8'h80); rq.push_back(8'h00);
        end
      end
      default: bad_frame++;
    endcase
  endtask

  task automatic model_byte(input logic [7:0] b, input logic cs, output logic [7:0] r);
    byte_cnt++; r = 8'hFF;
    if (cs) begin
      if (seen_cmd) gap_cnt++; else pwrup_cnt++;
      frame_cnt = 0;
    end else begin
      seen_cmd = 1;
      if ((frame_cnt == 0 && b[7:6] == 2'b01) || (frame_cnt > 0 && frame_cnt < 6)) begin
        frame[frame_cnt] = b; frame_cnt++;
        if (frame_cnt == 6) decode();
      end else if (rq.size() > 0) begin
        r = rq.pop_front();
      end
    end
  endtask

  logic [7:0] eng_r; int eng_d; bit eng_ab;
  // Byte engine: accepts a request, waits a random delay, pulses done with the card's reply.
  initial begin
    xfer_done = 1'b0; xfer_rx = 8'hFF; clear_model();
    forever begin
      @(negedge clk);
      if (reset || model_clr != clr_seen) begin
        clr_seen = model_clr; clear_model();
      end else if (req) begin
        model_byte(tx, cs_n, eng_r);
        eng_d = $urandom_range(dly_max, dly_min); eng_ab = 0;
        for (int i = 1; i < eng_d; i++) begin
          @(negedge clk);
          if (reset) begin eng_ab = 1; break; end
        end
        if (!eng_ab) begin
          xfer_done = 1'b1; xfer_rx = eng_r;
          @(negedge clk);
          xfer_done = 1'b0; xfer_rx = 8'hFF;
        end
      end
    end
  end

  logic p_req = 1'b0, p_cs = 1'b1, p_baud = 1'b0, p_rst = 1'b1;
  logic [7:0] p_tx = 8'hFF;
  // Handshake monitor sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (!reset && !p_rst) begin
      if (p_req && req && tx !== p_tx) viol_tx++;
      if (p_req && xfer_done && req) viol_hs++;
      if (p_req && !xfer_done && !req) viol_hs++;
      if (req && cs_n !== p_cs) viol_cs++;
      if (req && baud !== p_baud) viol_baud++;
    end
    p_req = req; p_cs = cs_n; p_baud = baud; p_rst = reset; p_tx = tx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(req), 32'h0);   chk({tag, "_tx"}, 32'(tx), 32'hFF);
    chk({tag, "_cs"}, 32'(cs_n), 32'h1);   chk({tag, "_baud"}, 32'(baud), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0); chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);   chk({tag, "_code"}, 32'(code), 32'h0);
    chk({tag, "_hc"}, 32'(hc), 32'h0);
  endtask

  task automatic prep(input int m, input int dmin, input int dmax);
    mode = m; dly_min = dmin; dly_max = dmax; model_clr = ~model_clr;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
  endtask

  task automatic wait_end(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    chk({tag, "_finished"}, 32'(done | err), 32'h1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    // Nominal card, plus a start pulse mid-sequence that must be ignored.
    prep(M_NOMINAL, 1, 3);
    pulse_start();
    chk("nom_busy", 32'(busy), 32'h1); chk("nom_baud_init", 32'(baud), 32'h0);
    repeat (40) @(negedge clk);
    pulse_start();
    wait_end(20000, "nom");
    chk("nom_done", 32'(done), 32'h1);  chk("nom_err", 32'(err), 32'h0);
    chk("nom_code", 32'(code), 32'h0);  chk("nom_busy_low", 32'(busy), 32'h0);
    chk("nom_baud", 32'(baud), 32'h1);  chk("nom_cs", 32'(cs_n), 32'h1);
    chk("nom_hc", 32'(hc), 32'(EXP_HC)); chk("nom_pwrup", 32'(pwrup_cnt), 32'd10);
    chk("nom_cmd0", 32'(cnt0), 32'd1);  chk("nom_cmd8", 32'(cnt8), 32'd1);
    chk("nom_cmd55", 32'(cnt55), 32'd3); chk("nom_acmd41", 32'(cnt41), 32'd3);
    chk("nom_cmd58", 32'(cnt58), 32'(EXP_CMD58));
    chk("nom_gaps", 32'(gap_cnt), 32'(EXP_GAPS));
    chk("nom_frames", 32'(bad_frame), 32'd0);

    // No card: every byte reads 0xFF.
    prep(M_NOCARD, 1, 3);
    pulse_start();
    chk("nc_done_clr", 32'(done), 32'h0); chk("nc_baud_init", 32'(baud), 32'h0);
    wait_end(20000, "nc");
    chk("nc_err", 32'(err), 32'h1);     chk("nc_code", 32'(code), 32'd1);
    chk("nc_cs", 32'(cs_n), 32'h1);     chk("nc_done", 32'(done), 32'h0);
    chk("nc_bytes", 32'(byte_cnt), 32'd25);

    // CMD8 echo mismatch.
    prep(M_ECHO, 1, 3);
    pulse_start();
    wait_end(20000, "echo");
    chk("echo_err", 32'(err), 32'h1);   chk("echo_code", 32'(code), 32'd3);
    chk("echo_baud", 32'(baud), 32'h0); chk("echo_cmd55", 32'(cnt55), 32'd0);

    // ACMD41 never leaves idle.
    prep(M_TIMEOUT, 1, 3);
    pulse_start();
    wait_end(20000, "to");
    chk("to_code", 32'(code), 32'd5);   chk("to_cmd55", 32'(cnt55), 32'd3);
    chk("to_acmd41", 32'(cnt41), 32'd3); chk("to_done", 32'(done), 32'h0);

    // Reset during the CMD8 argument byte, then restart.
    prep(M_NOMINAL, 20, 20);
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      if (req && frame_cnt == 2 && frame[0] == 8'h48) break;
      @(negedge clk);
    end
    chk("mid_reached", 32'(req && frame_cnt == 2 && frame[0] == 8'h48), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prep(M_NOMINAL, 1, 3);
    pulse_start();
    for (int i = 0; i < 100 && !req; i++) @(negedge clk);
    chk("rs_first_cs", 32'(cs_n), 32'h1); chk("rs_first_tx", 32'(tx), 32'hFF);
    wait_end(20000, "rs");
    chk("rs_done", 32'(done), 32'h1);   chk("rs_pwrup", 32'(pwrup_cnt), 32'd10);

    // Long random byte-engine latency.
    prep(M_NOMINAL, 1, 600);
    pulse_start();
    wait_end(60000, "st");
    chk("st_done", 32'(done), 32'h1);   chk("st_cmd55", 32'(cnt55), 32'd3);
    chk("st_frames", 32'(bad_frame), 32'd0);
    chk("hs_tx_stable", 32'(viol_tx), 32'd0); chk("hs_req_drop", 32'(viol_hs), 32'd0);
    chk("hs_cs", 32'(viol_cs), 32'd0);        chk("hs_baud", 32'(viol_baud), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
